// File: rtl/ip_lpm_pipelined_pkg.sv
// ip_lpm_pipelined_pkg
//   Shared definitions for the IPv4 LPM front end and its neighbours
//   (LUT and ARP stages): key width, default dst-IP word offsets,
//   a ceil-log2 helper and the saturating counter step.
package ip_lpm_pipelined_pkg;

  localparam int IP_KEY_W       = 32;
  localparam int IP_HALF_W      = 16;
  localparam int DEF_DST_HI_LSB = 0;
  localparam int DEF_DST_LO_LSB = 240;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Smallest r with 2**r >= n (0 for n <= 1).
  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Counter step that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != CNT_MAX)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// fallthrough_small_fifo
//   Small synchronous FIFO whose head entry is visible on dout_o without a
//   read (first-word fall-through). Writes while full and reads while empty
//   are ignored.
// Ports
//   clk, reset      clock, synchronous active-high reset (empties the FIFO)
//   wr_en_i, din_i  push request and data
//   rd_en_i         pop request
//   dout_o          head entry (meaningful only while empty_o = 0)
//   empty_o, full_o, nearly_full_o (at most one free entry), count_o
module fallthrough_small_fifo #(
  parameter int WIDTH          = 32,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en_i,
  input  logic [WIDTH-1:0]          din_i,
  input  logic                      rd_en_i,
  output logic [WIDTH-1:0]          dout_o,
  output logic                      empty_o,
  output logic                      full_o,
  output logic                      nearly_full_o,
  output logic [MAX_DEPTH_BITS:0]   count_o
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] FULL_LVL = (MAX_DEPTH_BITS + 1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0] NF_LVL   = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [MAX_DEPTH_BITS:0]   count_q, count_d;
  logic                      wr_ok, rd_ok;

  assign full_o        = (count_q == FULL_LVL);
  assign empty_o       = (count_q == '0);
  assign nearly_full_o = (count_q >= NF_LVL);
  assign count_o       = count_q;
  assign dout_o        = mem_q[rd_ptr_q];

  assign wr_ok = wr_en_i && !full_o;
  assign rd_ok = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + MAX_DEPTH_BITS'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + MAX_DEPTH_BITS'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (MAX_DEPTH_BITS + 1)'(1);
      2'b01:   count_d = count_q - (MAX_DEPTH_BITS + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only observed after it was written.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ip_dst_extract.sv
// ip_dst_extract
//   Latches the two halves of the IPv4 destination address from the
//   datapath and emits a one-cycle push pulse the cycle after the LO word,
//   when the assembled key is stable on key_o.
// Ports
//   clk, reset          clock, synchronous active-high reset
//   tdata_i             datapath word
//   hi_i                tdata_i carries dst_ip[31:16] at HI_LSB
//   lo_i                tdata_i carries dst_ip[15:0] at LO_LSB (key complete)
//   key_o               assembled key
//   push_o              key_o is a new complete key this cycle
module ip_dst_extract
  import ip_lpm_pipelined_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int HI_LSB = DEF_DST_HI_LSB,
  parameter int LO_LSB = DEF_DST_LO_LSB
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   tdata_i,
  input  logic                hi_i,
  input  logic                lo_i,
  output logic [IP_KEY_W-1:0] key_o,
  output logic                push_o
);

  logic [IP_HALF_W-1:0] hi_q, hi_d;
  logic [IP_HALF_W-1:0] lo_q, lo_d;
  logic                 push_q, push_d;

  // Only the two address slices of the word matter here.
  logic unused_tdata;
  assign unused_tdata = ^tdata_i;

  // HI and LO in the same cycle load both halves; the push follows LO.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    push_d = lo_i;
    if (hi_i) hi_d = tdata_i[HI_LSB +: IP_HALF_W];
    if (lo_i) lo_d = tdata_i[LO_LSB +: IP_HALF_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      push_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      push_q <= push_d;
    end
  end

  assign key_o  = {hi_q, lo_q};
  assign push_o = push_q;

endmodule

// File: rtl/ip_lpm_pipelined.sv
// ip_lpm_pipelined
//   IPv4 LPM front end: extracts the destination IP, queues keys, keeps up
//   to MAX_OUTSTANDING lookups in flight to the CAM LUT, buffers results for
//   the ARP stage and keeps hit/miss/drop statistics.
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   tdata, word_IP_DST_HI/LO      datapath word and dst-IP word markers
//   key_nearly_full               key FIFO has at most one free entry
//   lu_req, lu_key                one-cycle lookup request and its key
//   lu_ack, lu_hit, lu_oq, lu_next_hop   lookup completion (in issue order)
//   res_vld, res_rd               result available / pop
//   res_next_hop_ip, res_oq, res_hit     head result
//   clear_cnt                     clears the statistics
//   hit_cnt, miss_cnt, drop_cnt   saturating statistics
//   ack_err                       sticky: ack with nothing outstanding
//
// Handshakes: lu_req is a single-cycle request with no ready; the LUT
// answers every request with exactly one lu_ack, in order. res_vld/res_rd
// is valid/ready: a result moves on a cycle where both are high, and the
// head fields stay stable while res_vld=1 and res_rd=0.
module ip_lpm_pipelined
  import ip_lpm_pipelined_pkg::*;
#(
  parameter int                    C_S_AXIS_DATA_WIDTH = 256,
  parameter int                    NUM_QUEUES          = 8,
  parameter int                    KEY_FIFO_DEPTH_BITS = 2,
  parameter int                    RES_FIFO_DEPTH_BITS = 2,
  parameter int                    MAX_OUTSTANDING     = 2,
  parameter int                    DST_HI_LSB          = DEF_DST_HI_LSB,
  parameter int                    DST_LO_LSB          = DEF_DST_LO_LSB,
  parameter logic [NUM_QUEUES-1:0] MISS_OQ             = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0] tdata,
  input  logic                           word_IP_DST_HI,
  input  logic                           word_IP_DST_LO,
  output logic                           key_nearly_full,
  output logic                           lu_req,
  output logic [IP_KEY_W-1:0]            lu_key,
  input  logic                           lu_ack,
  input  logic                           lu_hit,
  input  logic [NUM_QUEUES-1:0]          lu_oq,
  input  logic [IP_KEY_W-1:0]            lu_next_hop,
  output logic                           res_vld,
  input  logic                           res_rd,
  output logic [IP_KEY_W-1:0]            res_next_hop_ip,
  output logic [NUM_QUEUES-1:0]          res_oq,
  output logic                           res_hit,
  input  logic                           clear_cnt,
  output logic [31:0]                    hit_cnt,
  output logic [31:0]                    miss_cnt,
  output logic [31:0]                    drop_cnt,
  output logic                           ack_err
);

  localparam int RES_DEPTH = 1 << RES_FIFO_DEPTH_BITS;
  localparam int PEND_BITS = (log2_ceil(MAX_OUTSTANDING) < 1) ? 1 : log2_ceil(MAX_OUTSTANDING);
  localparam int OUT_W     = log2_ceil(MAX_OUTSTANDING + 1);
  localparam int RES_W     = IP_KEY_W + NUM_QUEUES + 1;

  // ---------------- key extraction and key FIFO ----------------
  logic [IP_KEY_W-1:0] ext_key;
  logic                ext_push;

  ip_dst_extract #(
    .DATA_W (C_S_AXIS_DATA_WIDTH),
    .HI_LSB (DST_HI_LSB),
    .LO_LSB (DST_LO_LSB)
  ) u_extract (
    .clk     (clk),
    .reset   (reset),
    .tdata_i (tdata),
    .hi_i    (word_IP_DST_HI),
    .lo_i    (word_IP_DST_LO),
    .key_o   (ext_key),
    .push_o  (ext_push)
  );

  logic [IP_KEY_W-1:0]          key_head;
  logic                         key_empty, key_full;
  logic [KEY_FIFO_DEPTH_BITS:0] key_count_unused;
  logic                         issue;

  fallthrough_small_fifo #(
    .WIDTH          (IP_KEY_W),
    .MAX_DEPTH_BITS (KEY_FIFO_DEPTH_BITS)
  ) u_key_fifo (
    .clk           (clk),
    .reset         (reset),
    .wr_en_i       (ext_push),
    .din_i         (ext_key),
    .rd_en_i       (issue),
    .dout_o        (key_head),
    .empty_o       (key_empty),
    .full_o        (key_full),
    .nearly_full_o (key_nearly_full),
    .count_o       (key_count_unused)
  );

  // ---------------- issue / credit ----------------
  logic [OUT_W-1:0]             outstanding_q, outstanding_d;
  logic [RES_FIFO_DEPTH_BITS:0] res_count;
  logic                         ack_ok;
  logic                         lu_req_q;
  logic [IP_KEY_W-1:0]          lu_key_q, lu_key_d;
  logic                         ack_err_q, ack_err_d;

  // Credit: every in-flight lookup owns a result slot before it is issued,
  // so the result FIFO can never be asked to take an ack it has no room for.
  assign issue = !key_empty
              && (int'(outstanding_q) < MAX_OUTSTANDING)
              && ((int'(outstanding_q) + int'(res_count)) < RES_DEPTH);

  // An ack only counts when something is in flight; anything else is stray.
  assign ack_ok = lu_ack && (outstanding_q != '0);

  always_comb begin
    outstanding_d = outstanding_q;
    lu_key_d      = lu_key_q;
    ack_err_d     = ack_err_q;
    case ({issue, ack_ok})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
    if (issue) lu_key_d = key_head;
    if (lu_ack && (outstanding_q == '0)) ack_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_q <= '0;
      lu_req_q      <= 1'b0;
      lu_key_q      <= '0;
      ack_err_q     <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      lu_req_q      <= issue;
      lu_key_q      <= lu_key_d;
      ack_err_q     <= ack_err_d;
    end
  end

  assign lu_req  = lu_req_q;
  assign lu_key  = lu_key_q;
  assign ack_err = ack_err_q;

  // ---------------- pending keys (for next-hop fallback) ----------------
  logic [IP_KEY_W-1:0] pend_key;
  logic                pend_empty_unused, pend_full_unused, pend_nf_unused;
  logic [PEND_BITS:0]  pend_count_unused;

  fallthrough_small_fifo #(
    .WIDTH          (IP_KEY_W),
    .MAX_DEPTH_BITS (PEND_BITS)
  ) u_pend_fifo (
    .clk           (clk),
    .reset         (reset),
    .wr_en_i       (issue),
    .din_i         (key_head),
    .rd_en_i       (ack_ok),
    .dout_o        (pend_key),
    .empty_o       (pend_empty_unused),
    .full_o        (pend_full_unused),
    .nearly_full_o (pend_nf_unused),
    .count_o       (pend_count_unused)
  );

  // ---------------- result FIFO ----------------
  logic [IP_KEY_W-1:0]   nh_sel;
  logic [NUM_QUEUES-1:0] oq_sel;
  logic [RES_W-1:0]      res_din, res_dout;
  logic                  res_empty, res_full_unused, res_nf_unused;

  // A zero next hop means the destination is directly attached.
  assign nh_sel  = (lu_next_hop == '0) ? pend_key : lu_next_hop;
  assign oq_sel  = lu_hit ? lu_oq : MISS_OQ;
  assign res_din = {nh_sel, oq_sel, lu_hit};

  fallthrough_small_fifo #(
    .WIDTH          (RES_W),
    .MAX_DEPTH_BITS (RES_FIFO_DEPTH_BITS)
  ) u_res_fifo (
    .clk           (clk),
    .reset         (reset),
    .wr_en_i       (ack_ok),
    .din_i         (res_din),
    .rd_en_i       (res_rd),
    .dout_o        (res_dout),
    .empty_o       (res_empty),
    .full_o        (res_full_unused),
    .nearly_full_o (res_nf_unused),
    .count_o       (res_count)
  );

  // Head fields read as zero while empty so the outputs never show stale data.
  assign res_vld         = !res_empty;
  assign res_next_hop_ip = res_vld ? res_dout[RES_W-1 -: IP_KEY_W] : '0;
  assign res_oq          = res_vld ? res_dout[NUM_QUEUES:1] : '0;
  assign res_hit         = res_vld && res_dout[0];

  // ---------------- statistics ----------------
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    hit_cnt_d  = sat_inc(hit_cnt_q, ack_ok && lu_hit);
    miss_cnt_d = sat_inc(miss_cnt_q, ack_ok && !lu_hit);
    drop_cnt_d = sat_inc(drop_cnt_q, ext_push && key_full);
    if (clear_cnt) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_ip_lpm_pipelined.sv
`timescale 1ns/1ps
module tb_ip_lpm_pipelined;

  localparam int DW     = 256;
  localparam int NQ     = 8;
  localparam int HI_LSB = 0;
  localparam int LO_LSB = 240;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [DW-1:0] tdata;
  logic          word_IP_DST_HI, word_IP_DST_LO;
  logic          key_nearly_full;
  logic          lu_req;
  logic [31:0]   lu_key;
  logic          lu_ack, lu_hit;
  logic [NQ-1:0] lu_oq;
  logic [31:0]   lu_next_hop;
  logic          res_vld, res_rd;
  logic [31:0]   res_next_hop_ip;
  logic [NQ-1:0] res_oq;
  logic          res_hit;
  logic          clear_cnt;
  logic [31:0]   hit_cnt, miss_cnt, drop_cnt;
  logic          ack_err;

  ip_lpm_pipelined dut (
    .clk             (clk),
    .reset           (reset),
    .tdata           (tdata),
    .word_IP_DST_HI  (word_IP_DST_HI),
    .word_IP_DST_LO  (word_IP_DST_LO),
    .key_nearly_full (key_nearly_full),
    .lu_req          (lu_req),
    .lu_key          (lu_key),
    .lu_ack          (lu_ack),
    .lu_hit          (lu_hit),
    .lu_oq           (lu_oq),
    .lu_next_hop     (lu_next_hop),
    .res_vld         (res_vld),
    .res_rd          (res_rd),
    .res_next_hop_ip (res_next_hop_ip),
    .res_oq          (res_oq),
    .res_hit         (res_hit),
    .clear_cnt       (clear_cnt),
    .hit_cnt         (hit_cnt),
    .miss_cnt        (miss_cnt),
    .drop_cnt        (drop_cnt),
    .ack_err         (ack_err)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Counts lu_req pulses seen on the falling edge.
  int req_seen = 0;
  always @(negedge clk) begin
    if (lu_req) req_seen <= req_seen + 1;
  end

  // ---------------- driver tasks ----------------
  // Inputs change right after a falling edge; outputs are read there too.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_key();
    word_IP_DST_HI = 1'b0;
    word_IP_DST_LO = 1'b0;
    tdata          = '0;
  endtask

  task automatic set_key(input logic [31:0] k);
    tdata                       = '0;
    tdata[HI_LSB +: 16]         = k[31:16];
    tdata[LO_LSB +: 16]         = k[15:0];
    word_IP_DST_HI              = 1'b1;
    word_IP_DST_LO              = 1'b1;
  endtask

  task automatic send_key(input logic [31:0] k);
    set_key(k);
    step(1);
    idle_key();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
  endtask

  // Waits (bounded) for lu_req and checks the key it carries.
  task automatic wait_req(input string tag, input logic [31:0] exp_key, output int lat);
    lat = 0;
    while (!lu_req && lat < 20) begin
      step(1);
      lat++;
    end
    if (!lu_req) check_eq({tag, "_req_timeout"}, 32'd0, 32'd1);
    else         check_eq({tag, "_lu_key"}, lu_key, exp_key);
  endtask

  task automatic ack(input logic hit, input logic [NQ-1:0] oq, input logic [31:0] nh);
    lu_ack      = 1'b1;
    lu_hit      = hit;
    lu_oq       = oq;
    lu_next_hop = nh;
    step(1);
    lu_ack      = 1'b0;
    lu_hit      = 1'b0;
    lu_oq       = '0;
    lu_next_hop = '0;
  endtask

  task automatic pop();
    res_rd = 1'b1;
    step(1);
    res_rd = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [31:0] nh, input logic [NQ-1:0] oq,
                           input logic hit);
    check_eq({tag, "_vld"}, 32'(res_vld), 32'd1);
    check_eq({tag, "_nh"},  res_next_hop_ip, nh);
    check_eq({tag, "_oq"},  32'(res_oq), 32'(oq));
    check_eq({tag, "_hit"}, 32'(res_hit), 32'(hit));
  endtask

  task automatic do_lookup(input string tag, input logic [31:0] k, input logic hit,
                           input logic [NQ-1:0] oq, input logic [31:0] nh);
    int lat;
    send_key(k);
    wait_req(tag, k, lat);
    ack(hit, oq, nh);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_lu_req"},   32'(lu_req), 32'd0);
    check_eq({tag, "_lu_key"},   lu_key, 32'd0);
    check_eq({tag, "_res_vld"},  32'(res_vld), 32'd0);
    check_eq({tag, "_nfull"},    32'(key_nearly_full), 32'd0);
    check_eq({tag, "_res_nh"},   res_next_hop_ip, 32'd0);
    check_eq({tag, "_res_oq"},   32'(res_oq), 32'd0);
    check_eq({tag, "_res_hit"},  32'(res_hit), 32'd0);
    check_eq({tag, "_hit_cnt"},  hit_cnt, 32'd0);
    check_eq({tag, "_miss_cnt"}, miss_cnt, 32'd0);
    check_eq({tag, "_drop_cnt"}, drop_cnt, 32'd0);
    check_eq({tag, "_ack_err"},  32'(ack_err), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int base;
    reset     = 1'b1;
    lu_ack    = 1'b0;
    lu_hit    = 1'b0;
    lu_oq     = '0;
    lu_next_hop = '0;
    res_rd    = 1'b0;
    clear_cnt = 1'b0;
    idle_key();
    step(1);
    do_reset();
    check_idle_outputs("rst");

    // 1: hit, zero next hop -> next hop is the key itself; latency >= 3.
    send_key(32'h0A00_0105);
    wait_req("t1", 32'h0A00_0105, lat);
    check_eq("t1_latency_ge3", 32'(lat + 1 >= 3), 32'd1);
    ack(1'b1, 8'h04, 32'h0);
    check_res("t1_res", 32'h0A00_0105, 8'h04, 1'b1);
    check_eq("t1_hit_cnt", hit_cnt, 32'd1);
    pop();
    check_eq("t1_res_empty", 32'(res_vld), 32'd0);

    // 2: miss with HI and LO on different words -> MISS_OQ, nh = key.
    tdata = '0; tdata[HI_LSB +: 16] = 16'hC0A8; tdata[LO_LSB +: 16] = 16'hDEAD;
    word_IP_DST_HI = 1'b1;
    step(1);
    tdata = '0; tdata[HI_LSB +: 16] = 16'hBEEF; tdata[LO_LSB +: 16] = 16'h0164;
    word_IP_DST_HI = 1'b0;
    word_IP_DST_LO = 1'b1;
    step(1);
    idle_key();
    wait_req("t2", 32'hC0A8_0164, lat);
    ack(1'b0, 8'hFF, 32'h0);
    check_res("t2_res", 32'hC0A8_0164, 8'h00, 1'b0);
    check_eq("t2_miss_cnt", miss_cnt, 32'd1);
    check_eq("t2_hit_cnt", hit_cnt, 32'd1);
    pop();

    // 2b: hit with an explicit next hop.
    do_lookup("t2b", 32'h0A00_0202, 1'b1, 8'h10, 32'h0A00_00FE);
    check_res("t2b_res", 32'h0A00_00FE, 8'h10, 1'b1);
    check_eq("t2b_hit_cnt", hit_cnt, 32'd2);
    pop();

    // 3: stalled engine. Five keys -> two go out, three wait (nearly full).
    // Two more keys: the sixth fills the FIFO, the seventh is dropped.
    do_reset();
    base = req_seen;
    for (int i = 1; i <= 5; i++) begin
      set_key(32'h0B00_0000 + 32'(i));
      step(1);
    end
    idle_key();
    step(8);
    check_eq("t3_req_pulses", 32'(req_seen - base), 32'd2);
    check_eq("t3_nearly_full", 32'(key_nearly_full), 32'd1);
    check_eq("t3_no_drop_yet", drop_cnt, 32'd0);
    set_key(32'h0B00_0006);
    step(1);
    set_key(32'h0B00_0007);
    step(1);
    idle_key();
    step(3);
    check_eq("t3_drop_cnt", drop_cnt, 32'd1);
    check_eq("t3_req_pulses_after", 32'(req_seen - base), 32'd2);
    check_eq("t3_no_result", 32'(res_vld), 32'd0);

    // 5: reset with two lookups outstanding, then two stray acks.
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    check_eq("t5_ack_err_clear", 32'(ack_err), 32'd0);
    base = req_seen;
    ack(1'b1, 8'h01, 32'h0);
    ack(1'b0, 8'h00, 32'h0);
    step(6);
    check_eq("t5_res_vld", 32'(res_vld), 32'd0);
    check_eq("t5_ack_err", 32'(ack_err), 32'd1);
    check_eq("t5_hit_cnt", hit_cnt, 32'd0);
    check_eq("t5_miss_cnt", miss_cnt, 32'd0);
    check_eq("t5_drop_cnt", drop_cnt, 32'd0);
    check_eq("t5_no_req", 32'(req_seen - base), 32'd0);

    // 4: issue of B in the same cycle as the ack of A.
    do_reset();
    set_key(32'h0A00_0011);
    step(1);
    set_key(32'h0A00_0022);
    step(1);
    idle_key();
    wait_req("t4a", 32'h0A00_0011, lat);
    ack(1'b1, 8'h01, 32'h0);
    check_eq("t4_req_b", 32'(lu_req), 32'd1);
    check_eq("t4_key_b", lu_key, 32'h0A00_0022);
    check_eq("t4_outstanding", 32'(dut.outstanding_q), 32'd1);
    ack(1'b0, 8'h55, 32'h0);
    check_res("t4_first", 32'h0A00_0011, 8'h01, 1'b1);
    pop();
    check_res("t4_second", 32'h0A00_0022, 8'h00, 1'b0);
    pop();
    check_eq("t4_drained", 32'(res_vld), 32'd0);
    check_eq("t4_ack_err", 32'(ack_err), 32'd0);
    check_eq("t4_hit_cnt", hit_cnt, 32'd1);
    check_eq("t4_miss_cnt", miss_cnt, 32'd1);

    // 6: saturation, then clear beating a same-cycle hit.
    force dut.hit_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.hit_cnt_q;
    do_lookup("t6a", 32'h0A00_0301, 1'b1, 8'h02, 32'h0);
    check_eq("t6_hit_max", hit_cnt, 32'hFFFF_FFFF);
    pop();
    do_lookup("t6b", 32'h0A00_0302, 1'b1, 8'h02, 32'h0);
    check_eq("t6_hit_sat", hit_cnt, 32'hFFFF_FFFF);
    pop();
    send_key(32'h0A00_0303);
    wait_req("t6c", 32'h0A00_0303, lat);
    clear_cnt = 1'b1;
    ack(1'b1, 8'h02, 32'h0);
    clear_cnt = 1'b0;
    check_eq("t6_clear_hit", hit_cnt, 32'd0);
    check_eq("t6_clear_miss", miss_cnt, 32'd0);
    check_res("t6_res", 32'h0A00_0303, 8'h02, 1'b1);
    pop();
    do_lookup("t6d", 32'h0A00_0304, 1'b0, 8'h02, 32'h0);
    check_eq("t6_miss_after_clear", miss_cnt, 32'd1);
    check_eq("t6_hit_after_clear", hit_cnt, 32'd0);
    pop();

    // ---------------- report ----------------
    step(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
